// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register-file write port; one-cycle registered output stage, R15 writes rejected as faults.
// Ready is combinational and withheld under stall. Define RF_ARB_ROUND_ROBIN_EN for round-robin, otherwise B has fixed priority.
module rf_write_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         a_valid,
    input  logic [3:0]   a_addr,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [3:0]   b_addr,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         WE3,
    output logic [3:0]   A3,
    output logic [N-1:0] WD3,
    output logic         fault,
    output logic [7:0]   fault_count
);

    logic         last_grant;
    logic         win_b;
    logic         xfer;
    logic         is_r15;
    logic [3:0]   sel_addr;
    logic [N-1:0] sel_data;

    always_comb begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        win_b = ~last_grant;
`else
        win_b = 1'b1;
`endif
        a_ready  = !stall && a_valid && !(b_valid && win_b);
        b_ready  = !stall && b_valid && !(a_valid && !win_b);
        xfer     = a_ready || b_ready;
        sel_addr = b_ready ? b_addr : a_addr;
        sel_data = b_ready ? b_data : a_data;
        is_r15   = (sel_addr == 4'hF);
    end

    // R15 is reloaded from the PC every cycle, so a write to it is dropped and reported instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3         <= 1'b0;
            A3          <= 4'd0;
            WD3         <= '0;
            fault       <= 1'b0;
            fault_count <= 8'd0;
            last_grant  <= 1'b1;
        end else begin
            WE3   <= xfer && !is_r15;
            fault <= xfer && is_r15;
            if (xfer && !is_r15) begin
                A3  <= sel_addr;
                WD3 <= sel_data;
            end
            if (xfer) begin
                last_grant <= b_ready;
            end
            if (xfer && is_r15 && fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table for single-cycle behaviour plus sequences for contention, saturation and reset.
module tb_rf_write_arbiter;

`ifdef RF_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, a_valid, b_valid;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, WE3, fault;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [7:0]  fault_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rf [16];

    rf_write_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .WE3(WE3), .A3(A3), .WD3(WD3), .fault(fault), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    // Register file consumer of the write port.
    always @(posedge clk) begin
        if (WE3) rf[A3] <= WD3;
    end

    typedef struct {
        logic        st;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [3:0]  ba;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        we;
        logic [3:0]  a3;
        logic [31:0] wd;
        logic        flt;
        logic [7:0]  fc;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(input logic st, input logic av, input logic [3:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [3:0] ba, input logic [31:0] bd,
                                input logic ar, input logic br, input logic we, input logic [3:0] a3,
                                input logic [31:0] wd, input logic flt, input logic [7:0] fc);
        vec_t v;
        v.st = st; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.we = we; v.a3 = a3; v.wd = wd; v.flt = flt; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [3:0] ba, input logic [31:0] bd);
        stall = st; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = 32'd0;
        drive(0, 0, 0, 0, 0, 0, 0);

        vt[0]  = mk(0, 1, 4'd3,  32'hAA,       0, 4'd0,  32'h0,    1, 0, 1, 4'd3, 32'hAA,       0, 8'd0);
        vt[1]  = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,    0, 0, 0, 4'd3, 32'hAA,       0, 8'd0);
        vt[2]  = mk(0, 0, 4'd0,  32'h0,        1, 4'd9,  32'h99,   0, 1, 1, 4'd9, 32'h99,       0, 8'd0);
        vt[3]  = mk(1, 1, 4'd4,  32'h44,       0, 4'd0,  32'h0,    0, 0, 0, 4'd9, 32'h99,       0, 8'd0);
        vt[4]  = mk(1, 0, 4'd0,  32'h0,        1, 4'd6,  32'h66,   0, 0, 0, 4'd9, 32'h99,       0, 8'd0);
        vt[5]  = mk(1, 1, 4'd4,  32'h44,       1, 4'd6,  32'h66,   0, 0, 0, 4'd9, 32'h99,       0, 8'd0);
        vt[6]  = mk(0, 1, 4'd4,  32'h44,       0, 4'd0,  32'h0,    1, 0, 1, 4'd4, 32'h44,       0, 8'd0);
        vt[7]  = mk(0, 0, 4'd0,  32'h0,        1, 4'd15, 32'hDEAD, 0, 1, 0, 4'd4, 32'h44,       1, 8'd1);
        vt[8]  = mk(0, 1, 4'd0,  32'h12345678, 0, 4'd0,  32'h0,    1, 0, 1, 4'd0, 32'h12345678, 0, 8'd1);
        vt[9]  = mk(0, 1, 4'd15, 32'hBEEF,     0, 4'd0,  32'h0,    1, 0, 0, 4'd0, 32'h12345678, 1, 8'd2);
        vt[10] = mk(0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,    0, 0, 0, 4'd0, 32'h12345678, 0, 8'd2);

        // Reset values
        #1;
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_count", fault_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].st, vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
            #1;
            check($sformatf("v%0d_a_ready", i), a_ready, vt[i].ar);
            check($sformatf("v%0d_b_ready", i), b_ready, vt[i].br);
            @(negedge clk);
            check($sformatf("v%0d_we3", i), WE3, vt[i].we);
            check($sformatf("v%0d_a3", i), A3, vt[i].a3);
            check($sformatf("v%0d_wd3", i), WD3, vt[i].wd);
            check($sformatf("v%0d_fault", i), fault, vt[i].flt);
            check($sformatf("v%0d_fault_count", i), fault_count, vt[i].fc);
        end

        // Contention from reset: requesters hold until accepted
        do_reset();
        drive(0, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        #1;
        check("cont0_a_ready", a_ready, RR);
        check("cont0_b_ready", b_ready, !RR);
        @(negedge clk);
        check("cont0_we3", WE3, 1);
        check("cont0_a3", A3, RR ? 32'd1 : 32'd2);
        if (RR) drive(0, 0, 4'd0, 32'h0, 1, 4'd2, 32'h22);
        else    drive(0, 1, 4'd1, 32'h11, 0, 4'd0, 32'h0);
        #1;
        check("cont1_a_ready", a_ready, !RR);
        check("cont1_b_ready", b_ready, RR);
        @(negedge clk);
        check("cont1_we3", WE3, 1);
        check("cont1_a3", A3, RR ? 32'd2 : 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("cont2_we3", WE3, 0);

        // Continuous contention: alternate under round robin, B every time otherwise
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
            exp_b = RR ? (i % 2 == 1) : 1'b1;
            drive(0, 1, 4'd1, 32'(i), 1, 4'd2, 32'h100 + 32'(i));
            #1;
            check($sformatf("alt%0d_b_ready", i), b_ready, exp_b);
            check($sformatf("alt%0d_a_ready", i), a_ready, !exp_b);
            @(negedge clk);
            check($sformatf("alt%0d_a3", i), A3, exp_b ? 32'd2 : 32'd1);
            check($sformatf("alt%0d_wd3", i), WD3, exp_b ? 32'h100 + 32'(i) : 32'(i));
        end

        // Same destination: last writer wins
        do_reset();
        drive(0, 1, 4'd5, 32'h1, 1, 4'd5, 32'h2);
        @(negedge clk);
        if (RR) drive(0, 0, 4'd0, 32'h0, 1, 4'd5, 32'h2);
        else    drive(0, 1, 4'd5, 32'h1, 0, 4'd0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("same_addr_r5", rf[5], RR ? 32'h2 : 32'h1);

        // R15 faults saturate at 255
        do_reset();
        drive(0, 0, 4'd0, 32'h0, 1, 4'd15, 32'hDEAD);
        #1;
        check("r15_b_ready", b_ready, 1);
        @(negedge clk);
        check("r15_we3", WE3, 0);
        check("r15_fault", fault, 1);
        check("r15_fault_count", fault_count, 1);
        repeat (299) @(negedge clk);
        check("r15_sat_count", fault_count, 255);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("r15_sat_hold", fault_count, 255);
        check("r15_fault_clear", fault, 0);

        // Reset between accept and write
        do_reset();
        drive(0, 1, 4'd7, 32'h77, 0, 4'd0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("mid_we3_before", WE3, 1);
        rst = 1'b1;
        #1;
        check("mid_we3_async", WE3, 0);
        check("mid_fault_count", fault_count, 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_no_write_r7", rf[7], 0);
        check("mid_we3_after", WE3, 0);
        drive(0, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
        #1;
        check("mid_first_grant_a", a_ready, RR);
        check("mid_first_grant_b", b_ready, !RR);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: requester A (ALU result) and requester B (memory load result). Each cycle it grants at most one valid/ready transfer and drives the write port from a registered output stage. Writes to R15 are rejected because R15 is loaded every cycle from the PC input and is not writable through the port. The block sits between the execute/memory writeback paths and the register file.

## Interface
Parameters:
- N, 32, data width; must match the register file width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  when high, no grants are issued (both ready low).
- a_valid  in  1  requester A has a write pending.
- a_addr  in  4  requester A destination register.
- a_data  in  N  requester A write data.
- a_ready  out  1  requester A transfer accepted this cycle (combinational).
- b_valid  in  1  requester B has a write pending.
- b_addr  in  4  requester B destination register.
- b_data  in  N  requester B write data.
- b_ready  out  1  requester B transfer accepted this cycle (combinational).
- WE3  out  1  register-file write enable (registered).
- A3  out  4  register-file write address (registered).
- WD3  out  N  register-file write data (registered).
- fault  out  1  one-cycle pulse: an accepted request targeted R15 (registered).
- fault_count  out  8  saturating count of R15 faults.

## Operation
- Transfer on X occurs when X_valid && X_ready. At most one of a_ready, b_ready is high in any cycle.
- Ready logic: stall=1 -> both ready 0. Only one valid -> that requester's ready = 1. Both valid -> the arbitration winner's ready = 1, the loser's 0. Ready never depends on the requester's own data.
- Requesters hold valid, addr and data stable until accepted. The arbiter does not buffer losers.
- Arbitration state: last_grant (1 bit, 0=A, 1=B). It updates to the granted requester on every transfer, contended or not.
- Accepted with addr != 15: in the next cycle, WE3=1, A3=addr, WD3=data.
- Accepted with addr == 15: in the next cycle, WE3=0 and fault=1. fault_count increments, saturating at 255. The request counts as a grant for last_grant.
- No transfer in a cycle: in the next cycle, WE3=0 and fault=0. A3 and WD3 hold their previous values.
- Same destination address from both requesters in one cycle: normal arbitration; the loser's write lands in a later cycle (last writer wins).

## Timing
- Reset values: WE3=0, A3=0, WD3=0, fault=0, fault_count=0, last_grant=1 (so A wins the first contention).
- Latency: accept edge -> WE3 high for exactly one cycle starting after that edge. Data is readable at RD1/RD2 after the following edge.
- Throughput: one write per cycle. Under continuous contention in round-robin mode, grants strictly alternate.
- stall asserted: no accept in that cycle. The output stage still drains, so a write accepted in the prior cycle is still issued.
- rst asserted mid-operation: an accepted but not yet issued write is discarded. WE3 drops immediately (asynchronously). The first grant after release follows the reset value of last_grant.

## Configuration
- RF_ARB_ROUND_ROBIN_EN defined: on contention, the winner is the requester not equal to last_grant.
- RF_ARB_ROUND_ROBIN_EN undefined: fixed priority, B always wins contention. last_grant is still maintained but ignored.

## Test plan
- Reset, then A only: a_valid=1, a_addr=3, a_data=0x0000_00AA -> a_ready=1 same cycle; next cycle WE3=1, A3=3, WD3=0xAA; following cycle WE3=0.
- Contention, round robin: A(addr 1, 0x11) and B(addr 2, 0x22) both held valid for 4 cycles -> grant order A, B, then idle; WE3 writes A3=1, then A3=2 on consecutive cycles. Without the macro, B is written first.
- R15 reject: B valid, addr=15, data=0xDEAD -> b_ready=1; next cycle WE3=0, fault=1, fault_count=1. After 300 such requests, fault_count=255.
- Stall: A valid, stall=1 for 3 cycles -> a_ready=0 and WE3=0 throughout. After stall drops, accept happens, then WE3=1 one cycle later.
- Same address: A(addr 5, 0x1) and B(addr 5, 0x2) contending from reset, round robin -> A written, then B; register 5 ends at 0x2.
- Reset mid-flight: A accepted (addr 7), rst pulsed before the next edge -> WE3=0 immediately, no write to register 7, fault_count=0.
